// File: rtl/macguffin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : macguffin_pkg
// Description : Shared constants, packer state encoding and byte-slot helper
//               for the MacGuffin receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package macguffin_pkg;

    localparam int BLOCK_W         = 64;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } packer_state_t;

    // LSB position of byte slot k inside a block.
    function automatic int slot_lsb(input int k, input bit msb_first);
        return msb_first ? (BYTES_PER_BLOCK - 1 - k) * BYTE_W : k * BYTE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_block_packer_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : idle_timer
// Description : Inter-byte idle counter; expired is asserted combinationally
//               in the cycle the count reaches TIMEOUT_CYCLES-1 while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 86_800
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                 c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    assign expired = enable && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || expired) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_block_packer
// Description : Packs 8 UART bytes into a 64-bit AXI-Stream block; partial
//               blocks are discarded or zero-padded after an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_block_packer
    import macguffin_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 86_800,
    parameter int PAD_MODE       = 0,
    parameter int MSB_FIRST      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [BLOCK_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [15:0]        drop_count,
    output logic [3:0]         fill_level
);

    localparam logic [3:0]  c_FULL_CNT  = 4'(BYTES_PER_BLOCK);
    localparam logic [3:0]  c_LAST_SLOT = 4'(BYTES_PER_BLOCK - 1);
    localparam logic [15:0] c_DROP_MAX  = 16'hFFFF;

    packer_state_t      r_state, w_state_next;
    logic [3:0]         r_count, w_count_next;
    logic [BLOCK_W-1:0] r_acc, w_acc_next, w_merged;
    logic [BLOCK_W-1:0] r_out, w_out_next;
    logic               r_out_valid, w_out_valid_next;
    logic [15:0]        r_drop, w_drop_next;
    logic               w_byte_hs, w_out_free, w_expired, w_timer_clear;

    assign s_axis_tready = !rst && (r_count < c_FULL_CNT);
    assign w_byte_hs     = s_axis_tvalid && s_axis_tready;
    assign w_out_free    = !r_out_valid || m_axis_tready;
    assign w_timer_clear = w_byte_hs || (r_state != FILL);

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timer_clear),
        .enable  (r_state == FILL),
        .expired (w_expired)
    );

    // Unwritten slots are kept at zero, so padding only needs to advance the count.
    always_comb begin
        w_merged = r_acc;
        for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
            if (r_count == 4'(k)) begin
                w_merged[slot_lsb(k, MSB_FIRST != 0) +: BYTE_W] = s_axis_tdata;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_acc_next       = r_acc;
        w_out_next       = r_out;
        w_out_valid_next = r_out_valid && !m_axis_tready;
        w_drop_next      = r_drop;
        case (r_state)
            EMPTY: begin
                if (w_byte_hs) begin
                    w_acc_next   = w_merged;
                    w_count_next = r_count + 4'd1;
                    w_state_next = FILL;
                end
            end
            FILL: begin
                if (w_byte_hs) begin
                    if (r_count == c_LAST_SLOT && w_out_free) begin
                        // Final byte bypasses FULL straight into the output register.
                        w_out_next       = w_merged;
                        w_out_valid_next = 1'b1;
                        w_acc_next       = '0;
                        w_count_next     = '0;
                        w_state_next     = EMPTY;
                    end else begin
                        w_acc_next   = w_merged;
                        w_count_next = r_count + 4'd1;
                        if (r_count == c_LAST_SLOT) begin
                            w_state_next = FULL;
                        end
                    end
                end else if (w_expired) begin
                    if (PAD_MODE != 0) begin
                        w_count_next = c_FULL_CNT;
                        w_state_next = FULL;
                    end else begin
                        w_acc_next   = '0;
                        w_count_next = '0;
                        w_state_next = EMPTY;
                        if (r_drop != c_DROP_MAX) begin
                            w_drop_next = r_drop + 16'd1;
                        end
                    end
                end
            end
            FULL: begin
                if (w_out_free) begin
                    w_out_next       = r_acc;
                    w_out_valid_next = 1'b1;
                    w_acc_next       = '0;
                    w_count_next     = '0;
                    w_state_next     = EMPTY;
                end
            end
            default: begin
                w_acc_next   = '0;
                w_count_next = '0;
                w_state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_count     <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_acc       <= w_acc_next;
            r_out       <= w_out_next;
            r_out_valid <= w_out_valid_next;
            r_drop      <= w_drop_next;
        end
    end

    assign m_axis_tdata  = r_out;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = 1'b1;
    assign drop_count    = r_drop;
    assign fill_level    = r_count;

endmodule
`default_nettype wire
